// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//
// Shared types and constants for the push-button input stage of the
// mental-math game.
//
// Contents:
//    btn_state_t              - per-button debounce state
//    BTN_SEL / BTN_GE / BTN_LT - bit positions of each button in the i_btn,
//                               o_level and o_press vectors
//    DEFAULT_DEBOUNCE_CYCLES  - stable-sample count for 10 ms at 100 MHz
//
// Build option: BUTTON_DEBOUNCE_EN (see button_debounce.sv).
// ---------------------------------------------------------------------------
package button_pkg;

   // Debounce FSM states. IDLE and PRESS_WAIT present a released level,
   // HELD and RELEASE_WAIT present a pressed level.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Bit positions of the three game buttons.
   localparam int BTN_SEL = 0;
   localparam int BTN_GE  = 1;
   localparam int BTN_LT  = 2;

   // 10 ms worth of samples at 100 MHz.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditions one raw push-button line: a two-flop synchronizer followed by
// a debounce FSM with a saturating stable-sample counter. It reports the
// accepted level and a combinational accept strobe that is high during the
// cycle whose closing edge moves the FSM from PRESS_WAIT to HELD. The parent
// registers that strobe, so the registered press lines up with o_level.
//
// Parameters:
//    DEBOUNCE_CYCLES - consecutive stable synchronized samples needed to
//                      accept a level change (must be >= 2)
//    CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//    i_clk     - clock
//    i_rst     - synchronous active-high reset
//    i_btn     - raw asynchronous button level, 1 = pressed
//    o_level   - registered debounced level
//    o_accept  - high when the next edge accepts a press
//
// Build option BUTTON_DEBOUNCE_EN:
//    defined   - full debounce FSM and counter
//    undefined - counter and WAIT states compiled out; the level is a
//                registered copy of the synchronizer output and a press is
//                accepted on its 0->1 edge
// ---------------------------------------------------------------------------
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_accept
);

   logic r_sync1;
   logic r_sync2;

   // Two-flop synchronizer. i_btn is asynchronous to i_clk, so the first
   // flop may go metastable; only r_sync2 is ever used by downstream logic.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

`ifdef BUTTON_DEBOUNCE_EN

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   btn_state_t       r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_level;
   logic [CNT_W-1:0] w_countInc;
   logic             w_windowDone;

   // Saturating increment: the counter parks at CNT_MAX instead of
   // wrapping, so a stuck state can never alias back to a short count.
   assign w_countInc   = (r_count == CNT_MAX) ? CNT_MAX : r_count + CNT_ONE;

   // The entry cycle already counts as the first stable sample, so the
   // window closes when the incremented count reaches DEBOUNCE_CYCLES.
   assign w_windowDone = (w_countInc == CNT_MAX);

   // Debounce FSM. Any sample that disagrees with the pending level drops
   // straight back to the settled state, which restarts the accept window.
   // The level flop is updated on the same edge as the settling transition
   // so the level is a clean register output rather than a state decode.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_level <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_sync2) begin
                  r_state <= PRESS_WAIT;
                  r_count <= CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!r_sync2) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (w_windowDone) begin
                  r_state <= HELD;
                  r_count <= CNT_MAX;
                  r_level <= 1'b1;
               end else begin
                  r_count <= w_countInc;
               end
            end
            HELD: begin
               if (!r_sync2) begin
                  r_state <= RELEASE_WAIT;
                  r_count <= CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (r_sync2) begin
                  r_state <= HELD;
                  r_count <= '0;
               end else if (w_windowDone) begin
                  r_state <= IDLE;
                  r_count <= '0;
                  r_level <= 1'b0;
               end else begin
                  r_count <= w_countInc;
               end
            end
            default: begin
               r_state <= IDLE;
               r_count <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   // A press is accepted exactly on the PRESS_WAIT -> HELD transition.
   // Releases never raise this strobe.
   assign o_accept = (r_state == PRESS_WAIT) && r_sync2 && w_windowDone;
   assign o_level  = r_level;

`else

   // Debounce parameters are meaningless in this build; folding them into
   // an unused constant keeps the parameter list identical across builds.
   localparam int unusedCfg = DEBOUNCE_CYCLES + CNT_W;

   logic r_level;

   // Fast-simulation path: the level simply follows the synchronizer one
   // cycle later, so edge-to-level latency is three clocks.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level <= 1'b0;
      end else begin
         r_level <= r_sync2;
      end
   end

   // Press is the 0->1 edge of the level, seen one cycle early so the
   // parent's registered press coincides with the level rising.
   assign o_accept = r_sync2 & ~r_level;
   assign o_level  = r_level;

`endif

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Input stage of the mental-math game. Each raw, bouncing push button is
// synchronized and debounced by its own button_debounce instance; the
// accepted presses are then arbitrated so that at most one single-cycle
// press pulse reaches the game controller per clock.
//
// Parameters:
//    NUM_BTN         - number of buttons (bit 0 sel, bit 1 ge, bit 2 lt)
//    DEBOUNCE_CYCLES - stable samples needed to accept a change (>= 2)
//    CNT_W           - debounce counter width, derived; leave at default
//
// Ports:
//    i_clk      - clock
//    i_rst      - synchronous active-high reset
//    i_btn      - raw asynchronous button levels, 1 = pressed
//    o_level    - registered debounced level per button
//    o_press    - one-hot (or zero) single-cycle pulse per accepted press
//    o_conflict - single-cycle pulse when two or more presses were
//                 accepted on the same edge
//
// Build option BUTTON_DEBOUNCE_EN selects the full debounce FSM; without it
// every button uses the fast synchronizer-only path. Arbitration and the
// conflict flag behave identically in both builds.
// ---------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic               o_conflict
);

   localparam logic [NUM_BTN-1:0] ONE_VEC = NUM_BTN'(1);

   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] w_accept;
   logic [NUM_BTN-1:0] w_grant;
   logic               w_multi;
   logic [NUM_BTN-1:0] r_press;
   logic               r_conflict;

   // One independent conditioner per physical button.
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_btn    (i_btn[g]),
         .o_level  (w_level[g]),
         .o_accept (w_accept[g])
      );
   end

   // Lowest-index-wins arbitration: x & -x isolates the lowest set bit.
   // x & (x-1) clears it, so anything left over means a simultaneous press.
   // Losing buttons still settle into HELD inside their debouncers; only
   // their pulse is dropped, and they will not pulse again until released.
   assign w_grant = w_accept & (~w_accept + ONE_VEC);
   assign w_multi = |(w_accept & (w_accept - ONE_VEC));

   // Press and conflict registers. They load on the same edge that moves
   // the debouncer into HELD, so o_press rises together with o_level and
   // lasts exactly one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_press    <= '0;
         r_conflict <= 1'b0;
      end else begin
         r_press    <= w_grant;
         r_conflict <= w_multi;
      end
   end

   assign o_level    = w_level;
   assign o_press    = r_press;
   assign o_conflict = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed, table-driven bench for button_conditioner with
// DEBOUNCE_CYCLES = 4. Expectations follow whichever build is compiled:
// BUTTON_DEBOUNCE_EN defined (full debounce) or undefined (fast path).
// ---------------------------------------------------------------------------
module tb_button_conditioner;
   import button_pkg::*;

   localparam int NB = 3;
   localparam int D  = 4;

   logic          clk;
   logic          rst;
   logic [NB-1:0] btn;
   logic [NB-1:0] level;
   logic [NB-1:0] press;
   logic          conflict;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic          rst;
      logic [NB-1:0] btn;
      logic [NB-1:0] expLevel;
      logic [NB-1:0] expPress;
      logic          expConflict;
      string         name;
   } vec_t;

   vec_t vecs[$];

   button_conditioner #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_btn      (btn),
      .o_level    (level),
      .o_press    (press),
      .o_conflict (conflict)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [NB-1:0] b,
                               input logic [NB-1:0] l, input logic [NB-1:0] p,
                               input logic c, input string n);
      vec_t v;
      v.rst = r; v.btn = b; v.expLevel = l; v.expPress = p;
      v.expConflict = c; v.name = n;
      return v;
   endfunction

   // Drive inputs for the next edge.
   task automatic applyStimulus(input logic r, input logic [NB-1:0] b);
      rst = r;
      btn = b;
   endtask

   // Compare all three outputs as one vector.
   task automatic checkOutput(input string name, input logic [NB-1:0] l,
                              input logic [NB-1:0] p, input logic c);
      vecCount++;
      if (level !== l || press !== p || conflict !== c) begin
         missCount++;
         $display("[TB] FAIL %s: got level=%b press=%b conflict=%b, want level=%b press=%b conflict=%b",
                  name, level, press, conflict, l, p, c);
      end
   endtask

   // Apply inputs, take one rising edge, then sample 1 ns later.
   task automatic runEdge(input logic r, input logic [NB-1:0] b,
                          input logic [NB-1:0] l, input logic [NB-1:0] p,
                          input logic c, input string name);
      applyStimulus(r, b);
      @(posedge clk);
      #1;
      checkOutput(name, l, p, c);
   endtask

   initial begin
      applyStimulus(1'b1, '0);
      #2;

`ifdef BUTTON_DEBOUNCE_EN
      // Reset, then clean press of sel: pulse after edge 6.
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, "reset"));
      for (int k = 1; k <= D + 1; k++)
         vecs.push_back(mk(0, 3'b001, 3'b000, 3'b000, 0, "sel_wait"));
      vecs.push_back(mk(0, 3'b001, 3'b001, 3'b001, 0, "sel_press"));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 3'b001, 3'b001, 3'b000, 0, "sel_held"));
      // Release: level falls D+2 edges after the first 0 sample.
      for (int k = 1; k <= D + 1; k++)
         vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, "sel_rel_wait"));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, "sel_released"));
      // Simultaneous ge+lt: ge wins, conflict flagged.
      for (int k = 1; k <= D + 1; k++)
         vecs.push_back(mk(0, 3'b110, 3'b000, 3'b000, 0, "dual_wait"));
      vecs.push_back(mk(0, 3'b110, 3'b110, 3'b010, 1, "dual_press"));
      vecs.push_back(mk(0, 3'b110, 3'b110, 3'b000, 0, "dual_held"));
      for (int k = 1; k <= D + 1; k++)
         vecs.push_back(mk(0, 3'b000, 3'b110, 3'b000, 0, "dual_rel_wait"));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, "dual_released"));
`else
      // Fast path: level and press three edges after the first sample.
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, "reset"));
      vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, "lt_e1"));
      vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, "lt_e2"));
      vecs.push_back(mk(0, 3'b100, 3'b100, 3'b100, 0, "lt_press"));
      vecs.push_back(mk(0, 3'b100, 3'b100, 3'b000, 0, "lt_held"));
      vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, "lt_rel1"));
      vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, "lt_rel2"));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, "lt_released"));
      vecs.push_back(mk(0, 3'b011, 3'b000, 3'b000, 0, "dual_e1"));
      vecs.push_back(mk(0, 3'b011, 3'b000, 3'b000, 0, "dual_e2"));
      vecs.push_back(mk(0, 3'b011, 3'b011, 3'b001, 1, "dual_press"));
      vecs.push_back(mk(0, 3'b011, 3'b011, 3'b000, 0, "dual_held"));
      vecs.push_back(mk(0, 3'b000, 3'b011, 3'b000, 0, "dual_rel1"));
      vecs.push_back(mk(0, 3'b000, 3'b011, 3'b000, 0, "dual_rel2"));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, "dual_released"));
`endif

      foreach (vecs[i])
         runEdge(vecs[i].rst, vecs[i].btn, vecs[i].expLevel,
                 vecs[i].expPress, vecs[i].expConflict, vecs[i].name);

`ifdef BUTTON_DEBOUNCE_EN
      // Bounce on ge: 1,1,0 then steady 1; one pulse four stable samples
      // after the last 0, i.e. after edge 9.
      begin
         logic [6:0] pat;
         logic [NB-1:0] b;
         pat = 7'b1111011;
         for (int k = 1; k <= 10; k++) begin
            b = '0;
            b[BTN_GE] = (k <= 7) ? pat[k-1] : 1'b1;
            if (k < 9)
               runEdge(0, b, 3'b000, 3'b000, 0, "bounce_wait");
            else if (k == 9)
               runEdge(0, b, 3'b010, 3'b010, 0, "bounce_press");
            else
               runEdge(0, b, 3'b010, 3'b000, 0, "bounce_held");
         end
         for (int k = 1; k <= D + 1; k++)
            runEdge(0, 3'b000, 3'b010, 3'b000, 0, "bounce_rel_wait");
         runEdge(0, 3'b000, 3'b000, 3'b000, 0, "bounce_released");
      end

      // Three-cycle glitch on lt: never accepted.
      for (int k = 1; k <= 8; k++)
         runEdge(0, (k <= 3) ? 3'b100 : 3'b000, 3'b000, 3'b000, 0, "glitch");

      // Press sel, short release (3 cycles), hold again: no second pulse.
      for (int k = 1; k <= D + 1; k++)
         runEdge(0, 3'b001, 3'b000, 3'b000, 0, "rep_wait");
      runEdge(0, 3'b001, 3'b001, 3'b001, 0, "rep_press1");
      for (int k = 1; k <= 3; k++)
         runEdge(0, 3'b000, 3'b001, 3'b000, 0, "rep_short_rel");
      for (int k = 1; k <= 8; k++)
         runEdge(0, 3'b001, 3'b001, 3'b000, 0, "rep_no_pulse");
      // Full release, then re-press gives a second pulse.
      for (int k = 1; k <= D + 1; k++)
         runEdge(0, 3'b000, 3'b001, 3'b000, 0, "rep_rel_wait");
      runEdge(0, 3'b000, 3'b000, 3'b000, 0, "rep_released");
      for (int k = 1; k <= D + 1; k++)
         runEdge(0, 3'b001, 3'b000, 3'b000, 0, "rep_wait2");
      runEdge(0, 3'b001, 3'b001, 3'b001, 0, "rep_press2");
      for (int k = 1; k <= D + 2; k++)
         runEdge(0, 3'b000, (k <= D + 1) ? 3'b001 : 3'b000, 3'b000, 0, "rep_release2");

      // Reset during PRESS_WAIT with sel still held; one pulse at edge 6
      // after reset deasserts.
      for (int k = 1; k <= 4; k++)
         runEdge(0, 3'b001, 3'b000, 3'b000, 0, "rst_pre");
      runEdge(1, 3'b001, 3'b000, 3'b000, 0, "rst_mid_wait");
      for (int k = 1; k <= D + 1; k++)
         runEdge(0, 3'b001, 3'b000, 3'b000, 0, "rst_post_wait");
      runEdge(0, 3'b001, 3'b001, 3'b001, 0, "rst_post_press");
      runEdge(0, 3'b001, 3'b001, 3'b000, 0, "rst_post_held");
      // Reset while HELD clears the level immediately.
      runEdge(1, 3'b001, 3'b000, 3'b000, 0, "rst_held");
`else
      // Reset while held; re-press pulse three edges after deassert.
      runEdge(0, 3'b100, 3'b000, 3'b000, 0, "rst_pre1");
      runEdge(0, 3'b100, 3'b000, 3'b000, 0, "rst_pre2");
      runEdge(1, 3'b100, 3'b000, 3'b000, 0, "rst_mid");
      runEdge(0, 3'b100, 3'b000, 3'b000, 0, "rst_post1");
      runEdge(0, 3'b100, 3'b000, 3'b000, 0, "rst_post2");
      runEdge(0, 3'b100, 3'b100, 3'b100, 0, "rst_post_press");
      runEdge(0, 3'b100, 3'b100, 3'b000, 0, "rst_post_held");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
